// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
interface mem_stage_ctrl_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic              mem_stall;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_rd, mem_wr,
      input  mem_stall, mem_done, mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_rd, mem_wr,
      output mem_stall, mem_done, mem_rdata
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: runs multi-cycle loads/stores and writes MEM/WB only on completion.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHK_EN.
//
// state | meaning
// IDLE  | no access in flight; pass-through or launch a new access
// REQ   | request asserted with latched address/data, waiting for acceptance
// WAIT  | request accepted, waiting for mem_done
// DONE  | access finished; MEM/WB latches for one cycle
module mem_stage_ctrl #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              halt_in,
   input  logic [DATA_W-1:0] ALURes_in,
   input  logic [DATA_W-1:0] writedata_in,
   mem_stage_ctrl_if.master  mem,
   output logic [DATA_W-1:0] readdata_out,
   output logic              memwb_en,
   output logic              stall_out,
   output logic              err_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              access;
   logic              misalign;
   logic              start;
   logic              stall_raw;

   assign access = valid_in & (MemRead_in | MemWrite_in) & ~halt_in;

`ifdef MEM_MISALIGN_CHK_EN
   logic err_q, err_d;

   assign misalign = access & ALURes_in[0];
   assign err_d    = (state_q == IDLE) & misalign;
   assign err_out  = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end
`else
   assign misalign = 1'b0;
   assign err_out  = 1'b0;
`endif

   assign start = access & ~misalign;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = ALURes_in;
               wdata_d = writedata_in;
               rd_d    = MemRead_in;   // read wins when both op bits are set
               state_d = REQ;
            end
         end
         REQ: begin
            if (!mem.mem_stall) state_d = WAIT;
         end
         WAIT: begin
            if (mem.mem_done) begin
               if (rd_q) rdata_d = mem.mem_rdata;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Held in reset, the stage must look transparent to the rest of the pipeline.
   assign stall_raw = (state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & start);
   assign stall_out = rst & stall_raw;
   assign memwb_en  = ~stall_out;

   always_comb begin
      cnt_d = cnt_q;
      if (stall_out && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   assign mem.mem_rd    = (state_q == REQ) & rd_q;
   assign mem.mem_wr    = (state_q == REQ) & ~rd_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign readdata_out  = rdata_q;
   assign stall_cnt     = cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, stalls, reset mid-access, counter saturation.
module tb_mem_stage_ctrl;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic        halt_in;
   logic [15:0] ALURes_in;
   logic [15:0] writedata_in;
   logic [15:0] readdata_out;
   logic        memwb_en;
   logic        stall_out;
   logic        err_out;
   logic [3:0]  stall_cnt;

   int checks   = 0;
   int failures = 0;

   mem_stage_ctrl_if #(.DATA_W(16)) mif ();

   mem_stage_ctrl #(.DATA_W(16), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .MemRead_in   (MemRead_in),
      .MemWrite_in  (MemWrite_in),
      .halt_in      (halt_in),
      .ALURes_in    (ALURes_in),
      .writedata_in (writedata_in),
      .mem          (mif.master),
      .readdata_out (readdata_out),
      .memwb_en     (memwb_en),
      .stall_out    (stall_out),
      .err_out      (err_out),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0;
      valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; halt_in = 1'b0;
      ALURes_in = 16'h0040; writedata_in = 16'h0000;
      mif.mem_stall = 1'b0; mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;

      // Reset state, with a load presented to prove the stage stays transparent
      #3;
      chk("rst_mem_rd", 32'(mif.mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mif.mem_wr), 32'd0);
      chk("rst_mem_addr", 32'(mif.mem_addr), 32'h0);
      chk("rst_mem_wdata", 32'(mif.mem_wdata), 32'h0);
      chk("rst_readdata", 32'(readdata_out), 32'h0);
      chk("rst_memwb_en", 32'(memwb_en), 32'd1);
      chk("rst_stall_out", 32'(stall_out), 32'd0);
      chk("rst_err_out", 32'(err_out), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();
      rst = 1'b1;
      #1;

      // Reset asserted in WAIT of a load to 0x0040
      chk("midrst_idle_stall", 32'(stall_out), 32'd1);
      tick();
      chk("midrst_req_rd", 32'(mif.mem_rd), 32'd1);
      chk("midrst_req_addr", 32'(mif.mem_addr), 32'h0040);
      tick();
      chk("midrst_wait_rd", 32'(mif.mem_rd), 32'd0);
      rst = 1'b0; mif.mem_done = 1'b1; mif.mem_rdata = 16'h5A5A;
      #1;
      chk("midrst_rd_drop", 32'(mif.mem_rd), 32'd0);
      chk("midrst_memwb_en", 32'(memwb_en), 32'd1);
      chk("midrst_stall", 32'(stall_out), 32'd0);
      chk("midrst_readdata", 32'(readdata_out), 32'h0);
      chk("midrst_addr", 32'(mif.mem_addr), 32'h0);
      tick();
      valid_in = 1'b0; mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;
      rst = 1'b1;
      #1;
      chk("midrst_rel_readdata", 32'(readdata_out), 32'h0);
      chk("midrst_rel_cnt", 32'(stall_cnt), 32'd0);
      chk("midrst_rel_memwb", 32'(memwb_en), 32'd1);
      tick();
      chk("midrst_idle_rd", 32'(mif.mem_rd), 32'd0);

      // Minimum-latency load from 0x0040 returning 0xBEEF
      valid_in = 1'b1; MemRead_in = 1'b1; ALURes_in = 16'h0040;
      #1;
      chk("ld_idle_stall", 32'(stall_out), 32'd1);
      chk("ld_idle_memwb", 32'(memwb_en), 32'd0);
      chk("ld_idle_rd", 32'(mif.mem_rd), 32'd0);
      tick();
      chk("ld_req_rd", 32'(mif.mem_rd), 32'd1);
      chk("ld_req_addr", 32'(mif.mem_addr), 32'h0040);
      chk("ld_req_stall", 32'(stall_out), 32'd1);
      tick();
      chk("ld_wait_rd", 32'(mif.mem_rd), 32'd0);
      chk("ld_wait_stall", 32'(stall_out), 32'd1);
      mif.mem_done = 1'b1; mif.mem_rdata = 16'hBEEF;
      tick();
      mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000; valid_in = 1'b0;
      #1;
      chk("ld_done_readdata", 32'(readdata_out), 32'hBEEF);
      chk("ld_done_memwb", 32'(memwb_en), 32'd1);
      chk("ld_done_stall", 32'(stall_out), 32'd0);
      chk("ld_done_cnt", 32'(stall_cnt), 32'd3);
      tick();
      chk("ld_after_stall", 32'(stall_out), 32'd0);
      chk("ld_after_readdata", 32'(readdata_out), 32'hBEEF);

      // Store 0x1234 to 0x0010 with two stalled request cycles
      valid_in = 1'b1; MemRead_in = 1'b0; MemWrite_in = 1'b1;
      ALURes_in = 16'h0010; writedata_in = 16'h1234; mif.mem_stall = 1'b1;
      #1;
      chk("st_idle_stall", 32'(stall_out), 32'd1);
      chk("st_idle_wr", 32'(mif.mem_wr), 32'd0);
      tick();
      ALURes_in = 16'hFFFF; writedata_in = 16'h0000;
      #1;
      chk("st_req1_wr", 32'(mif.mem_wr), 32'd1);
      chk("st_req1_rd", 32'(mif.mem_rd), 32'd0);
      chk("st_req1_addr", 32'(mif.mem_addr), 32'h0010);
      chk("st_req1_wdata", 32'(mif.mem_wdata), 32'h1234);
      tick();
      chk("st_req2_wr", 32'(mif.mem_wr), 32'd1);
      chk("st_req2_addr", 32'(mif.mem_addr), 32'h0010);
      chk("st_req2_wdata", 32'(mif.mem_wdata), 32'h1234);
      tick();
      mif.mem_stall = 1'b0;
      #1;
      chk("st_req3_wr", 32'(mif.mem_wr), 32'd1);
      chk("st_req3_wdata", 32'(mif.mem_wdata), 32'h1234);
      tick();
      chk("st_wait_wr", 32'(mif.mem_wr), 32'd0);
      chk("st_wait_stall", 32'(stall_out), 32'd1);
      mif.mem_done = 1'b1; mif.mem_rdata = 16'hAAAA;
      tick();
      mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;
      valid_in = 1'b0; MemWrite_in = 1'b0;
      #1;
      chk("st_done_readdata", 32'(readdata_out), 32'hBEEF);
      chk("st_done_memwb", 32'(memwb_en), 32'd1);
      chk("st_done_cnt", 32'(stall_cnt), 32'd8);
      tick();

      // Non-memory op and halted load pass straight through
      valid_in = 1'b1; ALURes_in = 16'h0030;
      #1;
      chk("nop_stall", 32'(stall_out), 32'd0);
      chk("nop_memwb", 32'(memwb_en), 32'd1);
      tick();
      chk("nop_rd", 32'(mif.mem_rd), 32'd0);
      chk("nop_wr", 32'(mif.mem_wr), 32'd0);
      chk("nop_cnt", 32'(stall_cnt), 32'd8);
      MemRead_in = 1'b1; halt_in = 1'b1;
      #1;
      chk("halt_stall", 32'(stall_out), 32'd0);
      chk("halt_memwb", 32'(memwb_en), 32'd1);
      tick();
      chk("halt_rd", 32'(mif.mem_rd), 32'd0);
      chk("halt_cnt", 32'(stall_cnt), 32'd8);
      valid_in = 1'b0; MemRead_in = 1'b0; halt_in = 1'b0;

      // Spurious mem_done while idle
      mif.mem_done = 1'b1; mif.mem_rdata = 16'hFFFF;
      tick();
      mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;
      #1;
      chk("spur_readdata", 32'(readdata_out), 32'hBEEF);
      tick();

      // Back-to-back loads; done during acceptance is ignored
      valid_in = 1'b1; MemRead_in = 1'b1; ALURes_in = 16'h0020;
      tick();
      mif.mem_done = 1'b1; mif.mem_rdata = 16'hDEAD;
      tick();
      mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;
      #1;
      chk("b2b_acc_done_ignored", 32'(readdata_out), 32'hBEEF);
      chk("b2b_wait_stall", 32'(stall_out), 32'd1);
      tick();
      chk("b2b_still_wait", 32'(stall_out), 32'd1);
      mif.mem_done = 1'b1; mif.mem_rdata = 16'h1357;
      tick();
      mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;
      ALURes_in = 16'h0022; MemWrite_in = 1'b1;
      #1;
      chk("b2b_ld1_readdata", 32'(readdata_out), 32'h1357);
      chk("b2b_ld1_memwb", 32'(memwb_en), 32'd1);
      tick();
      chk("b2b_ld2_idle_stall", 32'(stall_out), 32'd1);
      tick();
      chk("b2b_ld2_rd", 32'(mif.mem_rd), 32'd1);
      chk("b2b_ld2_wr", 32'(mif.mem_wr), 32'd0);
      chk("b2b_ld2_addr", 32'(mif.mem_addr), 32'h0022);
      tick();
      mif.mem_done = 1'b1; mif.mem_rdata = 16'h2468;
      tick();
      mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;
      valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
      #1;
      chk("b2b_ld2_readdata", 32'(readdata_out), 32'h2468);
      chk("b2b_cnt", 32'(stall_cnt), 32'd15);
      tick();

      // Stall counter saturates at all-ones
      valid_in = 1'b1; MemWrite_in = 1'b1; ALURes_in = 16'h0050; mif.mem_stall = 1'b1;
      tick();
      tick();
      tick();
      chk("sat_cnt", 32'(stall_cnt), 32'd15);
      mif.mem_stall = 1'b0;
      tick();
      mif.mem_done = 1'b1;
      tick();
      mif.mem_done = 1'b0; valid_in = 1'b0; MemWrite_in = 1'b0;
      #1;
      chk("sat_cnt_done", 32'(stall_cnt), 32'd15);
      tick();

      // Odd address load
      valid_in = 1'b1; MemRead_in = 1'b1; ALURes_in = 16'h0041;
`ifdef MEM_MISALIGN_CHK_EN
      #1;
      chk("mis_rd", 32'(mif.mem_rd), 32'd0);
      chk("mis_stall", 32'(stall_out), 32'd0);
      chk("mis_memwb", 32'(memwb_en), 32'd1);
      chk("mis_err_pre", 32'(err_out), 32'd0);
      tick();
      valid_in = 1'b0; MemRead_in = 1'b0;
      #1;
      chk("mis_err", 32'(err_out), 32'd1);
      chk("mis_rd_after", 32'(mif.mem_rd), 32'd0);
      chk("mis_readdata", 32'(readdata_out), 32'h2468);
      tick();
      chk("mis_err_clear", 32'(err_out), 32'd0);
`else
      #1;
      chk("odd_stall", 32'(stall_out), 32'd1);
      chk("odd_err", 32'(err_out), 32'd0);
      tick();
      chk("odd_rd", 32'(mif.mem_rd), 32'd1);
      chk("odd_addr", 32'(mif.mem_addr), 32'h0041);
      tick();
      mif.mem_done = 1'b1; mif.mem_rdata = 16'h0F0F;
      tick();
      mif.mem_done = 1'b0; mif.mem_rdata = 16'h0000;
      valid_in = 1'b0; MemRead_in = 1'b0;
      #1;
      chk("odd_readdata", 32'(readdata_out), 32'h0F0F);
      chk("odd_err_done", 32'(err_out), 32'd0);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage access controller; the producer/writer side of the MEM/WB pipeline register.
- Takes an EX/MEM load/store, drives a multi-cycle 16-bit data memory with a request/accept/done handshake, and captures load data.
- Generates the MEM/WB write enable (memwb_en) and a stall back to earlier stages.
- memwb_en stays low until the access completes, so MEM/WB only latches finished results.

Parameters:
- DATA_W, 16: data and address width.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_in  in  1  EX/MEM holds a live instruction.
- MemRead_in  in  1  load.
- MemWrite_in  in  1  store.
- halt_in  in  1  halt instruction in MEM.
- ALURes_in  in  DATA_W  effective address.
- writedata_in  in  DATA_W  store data.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_stall  in  1  memory busy; request not accepted this cycle.
- mem_done  in  1  access complete; mem_rdata valid for a read.
- mem_rdata  in  DATA_W  memory read data.
- readdata_out  out  DATA_W  registered load data to MEM/WB.
- memwb_en  out  1  MEM/WB register write enable.
- stall_out  out  1  freeze PC/IF-ID/ID-EX/EX-MEM.
- err_out  out  1  misaligned-access flag (optional feature).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset values (async, rst=0): state IDLE; mem_rd=mem_wr=0; mem_addr=mem_wdata=0; readdata_out=0; err_out=0; stall_cnt=0.
- While in reset, memwb_en=1 and stall_out=0.
- access = valid_in & (MemRead_in | MemWrite_in) & ~halt_in. A halt never accesses memory.
- If MemRead_in and MemWrite_in are both set, the access is treated as a read.
- stall_out = (state != IDLE && state != DONE) | (state == IDLE & access).
- memwb_en = ~stall_out. It is combinational, with no extra cycle.
- IDLE:
  - On access: latch address, write data and op; go to REQ.
  - Otherwise: pass-through. memwb_en=1 and readdata_out holds its value.
- REQ:
  - mem_rd or mem_wr is asserted with latched mem_addr/mem_wdata.
  - If mem_stall=1: hold the request and stay in REQ.
  - Otherwise: request is accepted; deassert the request next cycle; go to WAIT.
- WAIT:
  - On mem_done=1: for a read, readdata_out <= mem_rdata; for a write, readdata_out is unchanged. Go to DONE.
  - Otherwise stay in WAIT.
- DONE: stall_out=0 and memwb_en=1 for exactly one cycle; go to IDLE.
- Minimum load latency: IDLE→REQ→WAIT→DONE, i.e. 3 stall cycles when mem_stall=0 and mem_done arrives the cycle after acceptance.
- mem_done is ignored outside WAIT.
- mem_done in the same cycle as acceptance in REQ is ignored; the memory must assert done in a later cycle.
- stall_cnt increments every cycle stall_out=1 and saturates at all-ones with no wrap.
- An async reset mid-access returns to IDLE immediately and drops mem_rd/mem_wr that cycle. No partial readdata update occurs.
- The memory is expected to keep mem_rdata stable only in the mem_done cycle; capture happens at that edge.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- With the macro defined:
  - An access with ALURes_in[0]=1 does not enter REQ and issues no memory request.
  - The block stays in IDLE with memwb_en=1 and readdata_out unchanged.
  - err_out is registered high for one cycle after the offending cycle.
  - The pipeline is expected to treat err_out as a halt.
- Without the macro: odd addresses access memory normally, and err_out is tied to 0.

Test Plan:
- Reset mid-WAIT of a load to 0x0040, then release → mem_rd=0 at once, readdata_out=0x0000, IDLE, memwb_en=1.
- Load from 0x0040, mem_stall=0, mem_done one cycle after acceptance with rdata 0xBEEF → stall_out high 3 cycles, readdata_out=0xBEEF, memwb_en pulses 1 in DONE, stall_cnt=3.
- Store 0x1234 to 0x0010 with mem_stall held 2 cycles → mem_wr held 3 cycles with stable addr/data, readdata_out unchanged, stall_cnt=5.
- Non-memory op (valid_in=1, MemRead=MemWrite=0) and halt_in=1 with MemRead=1 → no mem_rd/mem_wr, stall_out=0, memwb_en=1.
- Spurious mem_done in IDLE with rdata 0xFFFF → readdata_out unchanged; back-to-back loads each complete independently.
- With MEM_MISALIGN_CHK_EN, load from 0x0041 → no mem_rd, err_out=1 for one cycle, memwb_en=1. Without the macro → normal access, err_out=0.
